event_router_rr: RTL and testbench

//  Parametrised successor router: moves events from NUMCHANNELS local channel FIFOs into the shared chip FIFO.

---
 rtl/event_router_pkg.sv | 37 +++
 rtl/event_router_rr_arbiter.sv | 42 ++++
 rtl/event_router_rr.sv | 170 +++++++++++++++++
 tb/tb_event_router_rr.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_router_pkg.sv
// Shared definitions for the round-robin event router: FSM state codes,
// width helpers and a popcount used for the hit counter.
package event_router_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INTEGRATE = 3'd1;
  localparam logic [2:0] ST_SELECT    = 3'd2;
  localparam logic [2:0] ST_READ      = 3'd3;
  localparam logic [2:0] ST_WAIT      = 3'd4;
  localparam logic [2:0] ST_PUSH      = 3'd5;
  localparam logic [2:0] ST_FLUSH     = 3'd6;

  // Upper bound on channel count supported by the popcount helper
  localparam int MAX_CH = 1024;

  // Bits needed to hold a count of 0..n
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of set bits; callers zero-extend their vector to MAX_CH
  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/event_router_rr_arbiter.sv
// Combinational round-robin search: first set pending bit at or above the
// pointer, wrapping to index 0. Produces a one-hot grant and its index.
module rr_arbiter
  import event_router_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]          pending,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   index,
  output logic                  found
);

  localparam int IW = idx_w(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan N positions starting at ptr, keep the first pending one
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && pending[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/event_router_rr.sv
// Round-robin router from per-channel local FIFOs into the shared chip FIFO.
// Optional LightPix integration window: a window commits only if enough
// unmasked channels hold data before the timer expires, otherwise every
// participating channel is popped once and the window counts as dropped.
module event_router_rr
  import event_router_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int NUMCHANNELS = 64,
  parameter int TIMER_W     = 8,
  parameter int RD_LAT      = 1,
  parameter int DROP_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUMCHANNELS-1:0][WIDTH-2:0]     input_event,
  input  logic [NUMCHANNELS-1:0]                local_fifo_empty,
  input  logic [NUMCHANNELS-1:0]                channel_mask,
  input  logic                                  lightpix_mode,
  input  logic [$clog2(NUMCHANNELS+1)-1:0]      hit_threshold,
  input  logic [TIMER_W-1:0]                    timeout,
  output logic [NUMCHANNELS-1:0]                read_local_fifo_n,
  output logic [WIDTH-2:0]                      channel_event_out,
  output logic                                  event_valid,
  input  logic                                  event_ready,
  output logic                                  busy,
  output logic [DROP_W-1:0]                     dropped_count
);

  localparam int HW    = count_w(NUMCHANNELS);
  localparam int IW    = idx_w(NUMCHANNELS);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]              state;
  logic [TIMER_W-1:0]      timer;
  logic [NUMCHANNELS-1:0]  pending;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           sel_idx;
  logic [NUMCHANNELS-1:0]  sel_grant;
  logic [LAT_W-1:0]        lat_cnt;

  logic [NUMCHANNELS-1:0]  active;
  logic [MAX_CH-1:0]       active_ext;
  logic [HW-1:0]           hits;
  logic [HW-1:0]           thr_eff;
  logic [NUMCHANNELS-1:0]  pending_next;

  logic [NUMCHANNELS-1:0]  arb_grant;
  logic [IW-1:0]           arb_index;
  logic                    arb_found;

  // Unmasked channels holding data, their count, and the effective threshold
  always_comb begin
    active                       = ~local_fifo_empty & ~channel_mask;
    active_ext                   = '0;
    active_ext[NUMCHANNELS-1:0]  = active;
    hits                         = HW'(popcount(active_ext));
    thr_eff                      = (hit_threshold == '0) ? HW'(1) : hit_threshold;
    pending_next                 = pending & ~sel_grant;
  end

  rr_arbiter #(
    .N (NUMCHANNELS)
  ) u_arb (
    .pending (pending),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .index   (arb_index),
    .found   (arb_found)
  );

  // Main FSM with timer, read-latency counter, output and drop registers
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
    if (reset) begin
      state             <= ST_IDLE;
      timer             <= '0;
      pending           <= '0;
      rr_ptr            <= '0;
      sel_idx           <= '0;
      sel_grant         <= '0;
      lat_cnt           <= '0;
      channel_event_out <= '0;
      event_valid       <= 1'b0;
      dropped_count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hits != '0) begin
            state <= ST_INTEGRATE;
            timer <= '0;
          end
        end

        ST_INTEGRATE: begin
          timer <= timer + 1'b1;
          // Accept wins over timeout when both happen in the same cycle
          if (!lightpix_mode || (hits >= thr_eff)) begin
            pending <= active;
            state   <= (active != '0) ? ST_SELECT : ST_IDLE;
          end else if (timer == timeout) begin
            state <= ST_FLUSH;
          end
        end

        ST_SELECT: begin
          if (arb_found) begin
            sel_idx   <= arb_index;
            sel_grant <= arb_grant;
            state     <= ST_READ;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_READ: begin
          lat_cnt <= LAT_W'(RD_LAT - 1);
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_cnt == '0) begin
            channel_event_out <= input_event[sel_idx];
            event_valid       <= 1'b1;
            state             <= ST_PUSH;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        ST_PUSH: begin
          // Data and valid hold until the shared FIFO takes the word
          if (event_ready) begin
            event_valid <= 1'b0;
            pending     <= pending_next;
            rr_ptr      <= (sel_idx == IW'(NUMCHANNELS - 1)) ? '0 : sel_idx + 1'b1;
            state       <= (pending_next != '0) ? ST_SELECT : ST_IDLE;
          end
        end

        ST_FLUSH: begin
          if (dropped_count != '1) begin
            dropped_count <= dropped_count + 1'b1;
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Active-low pop strobes: one channel in READ, all participants in FLUSH
  always_comb begin
    read_local_fifo_n = '1;
    if (!reset) begin
      if (state == ST_READ) begin
        read_local_fifo_n = ~sel_grant;
      end else if (state == ST_FLUSH) begin
        read_local_fifo_n = ~active;
      end
    end
  end

  // Busy whenever the FSM is away from IDLE
  always_comb begin
    busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_event_router_rr.sv
// Directed bench for event_router_rr with a behavioural local-FIFO model
// (one-cycle read latency) and a log of words accepted by the shared FIFO.
module tb_event_router_rr;

  localparam int WIDTH   = 64;
  localparam int NCH     = 64;
  localparam int TIMER_W = 8;
  localparam int RD_LAT  = 1;
  localparam int DROP_W  = 4;
  localparam int HW      = $clog2(NCH + 1);

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NCH-1:0][WIDTH-2:0]   input_event;
  logic [NCH-1:0]              local_fifo_empty;
  logic [NCH-1:0]              channel_mask;
  logic                        lightpix_mode;
  logic [HW-1:0]               hit_threshold;
  logic [TIMER_W-1:0]          timeout;
  logic [NCH-1:0]              read_local_fifo_n;
  logic [WIDTH-2:0]            channel_event_out;
  logic                        event_valid;
  logic                        event_ready;
  logic                        busy;
  logic [DROP_W-1:0]           dropped_count;

  logic [WIDTH-2:0] fifo_q [NCH][$];
  logic [WIDTH-2:0] out_q [$];
  int               kn   [NCH];
  int               pops [NCH];
  logic [NCH-1:0]   pop_req;
  int               multi_strobe;
  int               total;
  int               bad;

  always #5 clk = ~clk;

  event_router_rr #(
    .WIDTH       (WIDTH),
    .NUMCHANNELS (NCH),
    .TIMER_W     (TIMER_W),
    .RD_LAT      (RD_LAT),
    .DROP_W      (DROP_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .input_event       (input_event),
    .local_fifo_empty  (local_fifo_empty),
    .channel_mask      (channel_mask),
    .lightpix_mode     (lightpix_mode),
    .hit_threshold     (hit_threshold),
    .timeout           (timeout),
    .read_local_fifo_n (read_local_fifo_n),
    .channel_event_out (channel_event_out),
    .event_valid       (event_valid),
    .event_ready       (event_ready),
    .busy              (busy),
    .dropped_count     (dropped_count)
  );

  function automatic logic [WIDTH-2:0] word(input int c, input int k);
    return (WIDTH-1)'((c << 8) | (k + 1));
  endfunction

  task automatic refresh_empty();
    for (int c = 0; c < NCH; c++) local_fifo_empty[c] = (fifo_q[c].size() == 0);
  endtask

  // Local FIFO model: a strobe seen mid-cycle pops the head into input_event
  // just after the next edge; transfers are logged on the same sample point.
  always begin
    @(negedge clk);
    pop_req = ~read_local_fifo_n;
    if (event_valid && event_ready) out_q.push_back(channel_event_out);
    if (!lightpix_mode && $countones(pop_req) > 1) multi_strobe++;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (pop_req[c]) begin
        pops[c]++;
        if (fifo_q[c].size() > 0) input_event[c] = fifo_q[c].pop_front();
      end
    end
    refresh_empty();
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q[c].push_back(word(c, kn[c]));
      kn[c]++;
    end
    refresh_empty();
  endtask

  task automatic wait_outs(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (out_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, 64'(out_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (!event_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, 64'(event_valid), 64'd1);
  endtask

  logic [WIDTH-2:0] exp_seq [6];
  int               cyc;

  initial begin
    total = 0;
    bad = 0;
    multi_strobe = 0;
    for (int c = 0; c < NCH; c++) begin
      kn[c] = 0;
      pops[c] = 0;
    end
    input_event      = '0;
    local_fifo_empty = '1;
    channel_mask     = '0;
    lightpix_mode    = 1'b0;
    hit_threshold    = '0;
    timeout          = '0;
    event_ready      = 1'b1;
    reset            = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_read_n", 64'(read_local_fifo_n), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_valid",  64'(event_valid), 64'd0);
    check("rst_data",   64'(channel_event_out), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_drop",   64'(dropped_count), 64'd0);
    reset = 1'b0;
    tick();

    // LArPix: ch5 and ch9 served in order, pointer lands past ch9
    load(5, 1);
    load(9, 1);
    wait_outs(2, 40, "larpix_count");
    wait_idle(10, "larpix_idle");
    check("larpix_out0", 64'(out_q[0]), 64'(word(5, 0)));
    check("larpix_out1", 64'(out_q[1]), 64'(word(9, 0)));
    check("larpix_ptr",  64'(dut.rr_ptr), 64'd10);
    check("larpix_pop5", 64'(pops[5]), 64'd1);
    check("larpix_pop9", 64'(pops[9]), 64'd1);

    // Move the pointer to 63 via ch62, then alternate ch63/ch0
    out_q.delete();
    load(62, 1);
    wait_outs(1, 40, "rr_pre_count");
    wait_idle(10, "rr_pre_idle");
    check("rr_pre_ptr", 64'(dut.rr_ptr), 64'd63);
    out_q.delete();
    load(0, 3);
    load(63, 3);
    exp_seq[0] = word(63, 0);
    exp_seq[1] = word(0, 0);
    exp_seq[2] = word(63, 1);
    exp_seq[3] = word(0, 1);
    exp_seq[4] = word(63, 2);
    exp_seq[5] = word(0, 2);
    wait_outs(6, 150, "rr_count");
    wait_idle(10, "rr_idle");
    for (int i = 0; i < 6; i++) check($sformatf("rr_out%0d", i), 64'(out_q[i]), 64'(exp_seq[i]));
    check("rr_ptr", 64'(dut.rr_ptr), 64'd1);

    // LightPix accept: third hit arrives well before the timeout
    out_q.delete();
    lightpix_mode = 1'b1;
    hit_threshold = HW'(3);
    timeout       = TIMER_W'(10);
    load(1, 1);
    tick(); tick(); tick();
    check("lpa_busy",  64'(busy), 64'd1);
    check("lpa_novalid", 64'(event_valid), 64'd0);
    load(2, 1);
    tick(); tick();
    load(4, 1);
    wait_outs(3, 60, "lpa_count");
    wait_idle(10, "lpa_idle");
    check("lpa_out0", 64'(out_q[0]), 64'(word(1, 0)));
    check("lpa_out1", 64'(out_q[1]), 64'(word(2, 0)));
    check("lpa_out2", 64'(out_q[2]), 64'(word(4, 0)));
    check("lpa_drop", 64'(dropped_count), 64'd0);

    // LightPix flush: two hits only, window expires at timer==10
    out_q.delete();
    load(7, 1);
    load(8, 1);
    for (int i = 0; i < 11; i++) tick();
    check("lpf_no_early_pop", 64'(read_local_fifo_n), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("lpf_strobe7", 64'(read_local_fifo_n[7]), 64'd0);
    check("lpf_strobe8", 64'(read_local_fifo_n[8]), 64'd0);
    check("lpf_busy",    64'(busy), 64'd1);
    tick();
    check("lpf_idle",  64'(busy), 64'd0);
    check("lpf_drop",  64'(dropped_count), 64'd1);
    check("lpf_pop7",  64'(pops[7]), 64'd1);
    check("lpf_pop8",  64'(pops[8]), 64'd1);
    check("lpf_noout", 64'(out_q.size()), 64'd0);

    // Backpressure with a masked nonempty channel
    lightpix_mode   = 1'b0;
    channel_mask[3] = 1'b1;
    event_ready     = 1'b0;
    load(3, 1);
    load(10, 1);
    wait_valid(20, "bp_valid");
    check("bp_data", 64'(channel_event_out), 64'(word(10, 0)));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", 64'(event_valid), 64'd1);
      check("bp_hold_data",  64'(channel_event_out), 64'(word(10, 0)));
    end
    check("bp_pop10", 64'(pops[10]), 64'd1);
    event_ready = 1'b1;
    wait_outs(1, 10, "bp_count");
    wait_idle(10, "bp_idle");
    check("bp_out", 64'(out_q[0]), 64'(word(10, 0)));
    tick(); tick(); tick();
    check("mask_stay_idle", 64'(busy), 64'd0);
    check("mask_pop3",      64'(pops[3]), 64'd0);
    check("mask_nonempty",  64'(local_fifo_empty[3]), 64'd0);

    // Reset while an event is waiting in PUSH
    event_ready = 1'b0;
    load(11, 1);
    wait_valid(20, "mid_valid");
    reset = 1'b1;
    tick();
    check("mid_read_n", 64'(read_local_fifo_n), 64'hFFFF_FFFF_FFFF_FFFF);
    check("mid_valid0", 64'(event_valid), 64'd0);
    check("mid_data0",  64'(channel_event_out), 64'd0);
    check("mid_busy0",  64'(busy), 64'd0);
    check("mid_drop0",  64'(dropped_count), 64'd0);
    check("mid_ptr0",   64'(dut.rr_ptr), 64'd0);
    reset = 1'b0;
    event_ready = 1'b1;
    tick(); tick(); tick();
    check("mid_after_idle", 64'(busy), 64'd0);
    check("mid_pop11",      64'(pops[11]), 64'd1);

    // Drop counter saturation with single-cycle windows
    lightpix_mode = 1'b1;
    hit_threshold = HW'(3);
    timeout       = '0;
    load(20, 15);
    cyc = 0;
    while ((fifo_q[20].size() != 0 || busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("sat_done15", 64'(busy), 64'd0);
    check("sat_drop15", 64'(dropped_count), 64'd15);
    load(20, 3);
    cyc = 0;
    tick();
    while ((fifo_q[20].size() != 0 || busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("sat_hold",   64'(dropped_count), 64'd15);
    check("sat_pop20",  64'(pops[20]), 64'd18);
    check("sat_noout",  64'(out_q.size()), 64'd1);

    check("single_strobe", 64'(multi_strobe), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
